cellrv32_npu_act_dispatch: RTL and testbench

//  Sequencer in front of cellrv32 NPU activation control: buffers activation instructions, issues one at a time.

---
 rtl/cellrv32_npu_act_dispatch.sv | 131 +++++++++++++
 tb/tb_cellrv32_npu_act_dispatch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_npu_act_dispatch.sv
// Activation-instruction dispatcher for the cellrv32 NPU.
// Queues instructions and issues them one at a time, holding back buffer-range overlaps.
package tpu_pkg;
  localparam int BUFFER_ADDRESS_WIDTH = 8;

  typedef struct packed {
    logic [3:0]                      op;
    logic [7:0]                      acc_addr;
    logic [BUFFER_ADDRESS_WIDTH-1:0] buff_addr;
    logic [BUFFER_ADDRESS_WIDTH-1:0] calc_len;
  } instruction_t;
endpackage

module cellrv32_npu_act_dispatch
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             flush_i,
  input  instruction_t     inst_i,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  output instruction_t     act_inst_o,
  output logic             act_inst_en_o,
  input  logic             act_busy_i,
  input  logic             act_resource_busy_i,
  output logic [CNT_W-1:0] pending_cnt_o,
  output logic             idle_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = BUFFER_ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    RUN
  } state_t;

  state_t           state_q;
  state_t           state_n;
  instruction_t     mem_q [FIFO_DEPTH];
  instruction_t     head;
  instruction_t     act_q;
  logic [CNT_W-1:0] wr_q;
  logic [CNT_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    lo_q;
  logic [AW-1:0]    hi_q;
  logic [AW-1:0]    head_lo;
  logic [AW-1:0]    head_hi;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             take;
  logic             overlap;

  assign cnt   = wr_q - rd_q;
  assign full  = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem_q[rd_q[PW-1:0]];

  assign head_lo = {1'b0, head.buff_addr};
  assign head_hi = head_lo + {1'b0, head.calc_len};
  assign overlap = !((head_hi < lo_q) || (head_lo > hi_q));

  assign inst_ready_o = !full && enable_i && !flush_i;
  assign push         = inst_valid_i && inst_ready_o;
  assign pop          = enable_i && (state_q == ISSUE);
  assign take         = enable_i && (state_q == IDLE) &&
                        (state_n == ISSUE);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        // a flush in the same cycle would leave the issued head stale
        if (!empty && !flush_i &&
            (!act_resource_busy_i || !overlap))
          state_n = ISSUE;
      end
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (act_busy_i) state_n = RUN;
      RUN:       if (!act_busy_i) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (enable_i && push)
      mem_q[wr_q[PW-1:0]] <= inst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      act_q   <= '0;
    end else if (enable_i) begin
      state_q <= state_n;
      if (push)
        wr_q <= wr_q + 1'b1;
      if (flush_i)
        rd_q <= wr_q;
      else if (pop)
        rd_q <= rd_q + 1'b1;
      // capture on the way into ISSUE so the strobe cycle already shows it
      if (take) begin
        act_q <= head;
        lo_q  <= head_lo;
        hi_q  <= head_hi;
      end
    end
  end

  assign act_inst_o    = act_q;
  assign act_inst_en_o = pop;
  assign pending_cnt_o = cnt;
  assign idle_o        = empty && (state_q == IDLE) &&
                         !act_resource_busy_i;

endmodule

// File: tb/tb_cellrv32_npu_act_dispatch.sv
// Directed scoreboard bench for cellrv32_npu_act_dispatch.
// Issued instructions are queued on push and checked on each strobe.
module tb_cellrv32_npu_act_dispatch;
  import tpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          flush_i;
  instruction_t  inst_i;
  logic          inst_valid_i;
  logic          inst_ready_o;
  instruction_t  act_inst_o;
  logic          act_inst_en_o;
  logic          act_busy_i;
  logic          act_resource_busy_i;
  logic [CW-1:0] pending_cnt_o;
  logic          idle_o;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  instruction_t exp_q [$];

  cellrv32_npu_act_dispatch #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .flush_i            (flush_i),
    .inst_i             (inst_i),
    .inst_valid_i       (inst_valid_i),
    .inst_ready_o       (inst_ready_o),
    .act_inst_o         (act_inst_o),
    .act_inst_en_o      (act_inst_en_o),
    .act_busy_i         (act_busy_i),
    .act_resource_busy_i(act_resource_busy_i),
    .pending_cnt_o      (pending_cnt_o),
    .idle_o             (idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic instruction_t mk(input logic [7:0] ba,
                                      input logic [7:0] len,
                                      input logic [3:0] op);
    instruction_t t;
    t.op        = op;
    t.acc_addr  = ba ^ 8'h5a;
    t.buff_addr = ba;
    t.calc_len  = len;
    return t;
  endfunction

  always @(negedge clk) begin
    if (act_inst_en_o === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0)
        chk("strobe_expected", 64'(exp_q.size()), 64'd1);
      else
        chk("act_inst", 64'(act_inst_o), 64'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input instruction_t t, output logic ok);
    inst_i       = t;
    inst_valid_i = 1'b1;
    #2;
    ok = inst_ready_o;
    if (ok)
      exp_q.push_back(t);
    @(posedge clk);
    #1;
    inst_valid_i = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int max);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      cyc();
      if (act_inst_en_o === 1'b1)
        got = 1'b1;
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  initial begin
    logic ok;
    int   s0;
    rst_i = 1'b1;
    enable_i = 1'b1;
    flush_i = 1'b0;
    inst_i = '0;
    inst_valid_i = 1'b0;
    act_busy_i = 1'b0;
    act_resource_busy_i = 1'b0;

    // reset
    repeat (2) cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_ready", 64'(inst_ready_o), 64'd1);
    chk("rst_en", 64'(act_inst_en_o), 64'd0);
    chk("rst_cnt", 64'(pending_cnt_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_inst", 64'(act_inst_o), 64'd0);

    // single issue latency
    s0 = strobes;
    push(mk(8'h10, 8'h04, 4'h1), ok);
    chk("t2_push", 64'(ok), 64'd1);
    chk("t2_cnt1", 64'(pending_cnt_o), 64'd1);
    chk("t2_en_early", 64'(act_inst_en_o), 64'd0);
    chk("t2_not_idle", 64'(idle_o), 64'd0);
    cyc();
    chk("t2_en", 64'(act_inst_en_o), 64'd1);
    chk("t2_inst", 64'(act_inst_o), 64'(mk(8'h10, 8'h04, 4'h1)));
    cyc();
    chk("t2_en_off", 64'(act_inst_en_o), 64'd0);
    chk("t2_cnt0", 64'(pending_cnt_o), 64'd0);
    chk("t2_one_strobe", 64'(strobes - s0), 64'd1);
    act_busy_i = 1'b1;
    repeat (2) cyc();
    act_busy_i = 1'b0;
    repeat (2) cyc();
    chk("t2_idle", 64'(idle_o), 64'd1);

    // overlapping head waits for resource drain
    push(mk(8'h10, 8'h08, 4'h2), ok);
    wait_strobe("t3_a_strobe", 5);
    act_busy_i = 1'b1;
    act_resource_busy_i = 1'b1;
    push(mk(8'h14, 8'h02, 4'h3), ok);
    chk("t3_b_push", 64'(ok), 64'd1);
    cyc();
    act_busy_i = 1'b0;
    s0 = strobes;
    repeat (5) cyc();
    chk("t3_b_held", 64'(strobes - s0), 64'd0);
    chk("t3_b_cnt", 64'(pending_cnt_o), 64'd1);
    act_resource_busy_i = 1'b0;
    cyc();
    chk("t3_b_issue", 64'(act_inst_en_o), 64'd1);
    cyc();
    act_busy_i = 1'b1;
    repeat (2) cyc();
    act_busy_i = 1'b0;
    repeat (2) cyc();

    // non-overlapping head issues while resource still busy
    push(mk(8'h10, 8'h08, 4'h4), ok);
    wait_strobe("t4_a_strobe", 5);
    act_busy_i = 1'b1;
    act_resource_busy_i = 1'b1;
    push(mk(8'h40, 8'h04, 4'h5), ok);
    cyc();
    act_busy_i = 1'b0;
    cyc();
    chk("t4_b_not_yet", 64'(act_inst_en_o), 64'd0);
    cyc();
    chk("t4_b_issue", 64'(act_inst_en_o), 64'd1);
    chk("t4_b_inst", 64'(act_inst_o), 64'(mk(8'h40, 8'h04, 4'h5)));
    cyc();
    act_busy_i = 1'b1;
    repeat (2) cyc();
    act_busy_i = 1'b0;
    act_resource_busy_i = 1'b0;
    repeat (2) cyc();

    // full queue and flush
    push(mk(8'h80, 8'h04, 4'h6), ok);
    wait_strobe("t5_x_strobe", 5);
    act_busy_i = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < DEPTH; i++) begin
      push(mk(8'(i * 32), 8'h04, 4'h7), ok);
      chk("t5_fill", 64'(ok), 64'd1);
    end
    chk("t5_cnt_full", 64'(pending_cnt_o), 64'(DEPTH));
    chk("t5_ready_full", 64'(inst_ready_o), 64'd0);
    push(mk(8'hc0, 8'h04, 4'h8), ok);
    chk("t5_fifth_refused", 64'(ok), 64'd0);
    chk("t5_cnt_still", 64'(pending_cnt_o), 64'(DEPTH));
    s0 = strobes;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    exp_q.delete();
    chk("t5_cnt_flushed", 64'(pending_cnt_o), 64'd0);
    chk("t5_run_kept", 64'(idle_o), 64'd0);
    chk("t5_inst_kept", 64'(act_inst_o), 64'(mk(8'h80, 8'h04, 4'h6)));
    act_busy_i = 1'b0;
    repeat (3) cyc();
    chk("t5_no_strobe", 64'(strobes - s0), 64'd0);
    chk("t5_idle", 64'(idle_o), 64'd1);

    // enable low during ISSUE
    push(mk(8'h20, 8'h04, 4'h9), ok);
    cyc();
    chk("t6_issue", 64'(act_inst_en_o), 64'd1);
    s0 = strobes;
    enable_i = 1'b0;
    #1;
    chk("t6_ready_off", 64'(inst_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_en_frozen", 64'(act_inst_en_o), 64'd0);
      chk("t6_cnt_frozen", 64'(pending_cnt_o), 64'd1);
      cyc();
    end
    enable_i = 1'b1;
    #1;
    chk("t6_en_back", 64'(act_inst_en_o), 64'd1);
    cyc();
    chk("t6_one_strobe", 64'(strobes - s0), 64'd1);
    chk("t6_cnt0", 64'(pending_cnt_o), 64'd0);
    act_busy_i = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("t6_rst_idle", 64'(idle_o), 64'd1);
    chk("t6_rst_inst", 64'(act_inst_o), 64'd0);
    act_busy_i = 1'b0;

    // reset with a queued head abandons it
    s0 = strobes;
    push(mk(8'h30, 8'h04, 4'ha), ok);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
    repeat (3) cyc();
    chk("t6_rst_no_strobe", 64'(strobes - s0), 64'd0);
    chk("t6_rst_cnt", 64'(pending_cnt_o), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
